playback_sequencer: RTL
=======================

Name: playback_sequencer

Overview:
Sequences the audio playback datapath between the on-board flash Avalon-MM read port and the audio codec write handshake. It fetches 32-bit flash words, buffers them in a small word FIFO, unpacks each word into two signed 16-bit samples, attenuates them, and applies the playback-speed mode (normal / chipmunk / laidback). It replaces ad-hoc per-task FSMs, and the top level simply wires flash, codec, SW and KEY to it.

Parameters:
ADDR_W, 23, flash word-address width
NUM_WORDS, 1048576, words in the sample image; last address is NUM_WORDS-1
FIFO_DEPTH, 4, word FIFO depth (power of 2, >=2)
SHIFT, 6, attenuation: sample divided by 2**SHIFT

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high reset
mode  in  2  00/11 normal, 01 chipmunk, 10 laidback
play_en  in  1  1 = run; 0 = pause
flash_mem_read  out  1  Avalon read request
flash_mem_address  out  ADDR_W  Avalon word address
flash_mem_waitrequest  in  1  Avalon stall
flash_mem_readdata  in  32  Avalon read data
flash_mem_readdatavalid  in  1  Avalon read data valid
write_ready  in  1  codec can accept a sample
write_s  out  1  codec write strobe
writedata_left  out  16  left sample
writedata_right  out  16  right sample (always equals left)
wrap_pulse  out  1  one-cycle pulse when address wraps to 0
fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Reset (sync, active-high, on any cycle): all outputs 0, FIFO flushed, both FSMs to idle. Reset mid-transaction abandons it; a readdatavalid arriving after reset is ignored.
- Fetch FSM: F_IDLE -> F_REQ when play_en=1 and (fifo_level + outstanding) < FIFO_DEPTH. Max one read outstanding.
- F_REQ: flash_mem_read=1, address held stable until waitrequest=0 at a clock edge (accept). Then -> F_DATA with read deasserted the next cycle.
- F_DATA: on readdatavalid, push readdata to the FIFO and go to F_IDLE.
- Address increments on accept. At NUM_WORDS-1 it wraps to 0 and asserts wrap_pulse for one cycle.
- play_en=0: no new request is issued. A request already in F_REQ or F_DATA completes normally.
- Output FSM: O_IDLE -> O_POP when FIFO is non-empty and play_en=1. O_POP pops one word and latches mode; a mode change takes effect on the next word. Then -> O_WR.
- O_WR: wait for write_ready=1. On that cycle assert write_s=1 for exactly one cycle with writedata_left and writedata_right driven. write_s=0 and data=0 in all other cycles. -> O_LOW.
- O_LOW: wait for write_ready=0, then select the next sample or return to O_IDLE.
- Sample order per word: low half [15:0] first, then [31:16].
- Normal: writes low, high.
- Chipmunk: writes the high half only (2x rate).
- Laidback: writes low, low, high, high (0.5x rate).
- Scaling: signed 16-bit value / 2**SHIFT, truncating toward zero (not an arithmetic shift). Example with SHIFT=6: -65 -> -1, -1 -> 0, 64 -> 1. The result is sign-extended to 16 bits.
- FIFO full: the fetch FSM stalls in F_IDLE. Outstanding-read accounting guarantees no overflow.
- FIFO empty: the output FSM waits in O_IDLE; no write_s is emitted (underflow is silent).
- Push and pop in the same cycle: fifo_level is unchanged.
- play_en dropping mid-word: the current word's remaining samples finish, then the output FSM holds in O_IDLE.

Decomposition:
- playback_pkg: mode_t enum (MODE_NORMAL, MODE_CHIPMUNK, MODE_LAIDBACK), fetch_state_t, out_state_t, default constants.
- One sub-module, sample_fifo: synchronous FIFO, 32-bit x FIFO_DEPTH, with push/pop/full/empty/level. Simultaneous push and pop are allowed when full or empty.

Test Plan:
- Normal, flash model 2-cycle waitrequest then valid, word 0x0040FFBF at addr 0, write_ready toggling -> write_s pulses carry 0xFFFF (-65/64) then 0x0001. The address stays 0 while waitrequest=1, then becomes 1 after accept.
- Chipmunk, words 0x01000080 and 0x02000100 -> exactly two write_s pulses, data 0x0004 then 0x0008. Sample rate is 2x normal.
- Laidback, word 0x0080FFC0 -> four pulses, data 0xFFFF, 0xFFFF, 0x0002, 0x0002.
- NUM_WORDS=4, preload, run to wrap -> addresses 0,1,2,3,0. wrap_pulse is high for exactly one cycle on the 3->0 accept.
- Codec stalled (write_ready=0) -> fifo_level saturates at FIFO_DEPTH and flash_mem_read stays 0. Raising write_ready resumes with no lost or duplicated words.
- Reset asserted during F_DATA with a late readdatavalid -> all outputs 0 the next cycle, the late data is not pushed, and fifo_level=0.

Source files
------------

// File: rtl/playback_pkg.sv
// Shared types and helpers for the audio playback sequencer: speed modes,
// FSM state encodings and the per-mode sample ordering.
package playback_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'b00,
    MODE_CHIPMUNK = 2'b01,
    MODE_LAIDBACK = 2'b10
  } mode_t;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t F_IDLE = 2'd0;
  localparam fetch_state_t F_REQ  = 2'd1;
  localparam fetch_state_t F_DATA = 2'd2;

  typedef logic [1:0] out_state_t;
  localparam out_state_t O_IDLE = 2'd0;
  localparam out_state_t O_POP  = 2'd1;
  localparam out_state_t O_WR   = 2'd2;
  localparam out_state_t O_LOW  = 2'd3;

  localparam int DEF_ADDR_W     = 23;
  localparam int DEF_NUM_WORDS  = 1048576;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_SHIFT      = 6;

  // Encoding 11 is treated as normal speed.
  function automatic mode_t decode_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_NORMAL : mode_t'(m);
  endfunction

  function automatic logic [1:0] last_step(input mode_t m);
    case (m)
      MODE_CHIPMUNK: return 2'd0;
      MODE_LAIDBACK: return 2'd3;
      default:       return 2'd1;
    endcase
  endfunction

  // 1 selects the high half-word for the given step within a word.
  function automatic logic step_half(input mode_t m, input logic [1:0] step);
    case (m)
      MODE_CHIPMUNK: return 1'b1;
      MODE_LAIDBACK: return step[1];
      default:       return step[0];
    endcase
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous word FIFO between the flash fetch side and the codec output side.
// Simultaneous push and pop are accepted when full, and pass through when empty.
module sample_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);
  assign rdata   = empty ? wdata : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/playback_sequencer.sv
// Flash-to-codec playback sequencer: fetches 32-bit sample words over Avalon-MM,
// buffers them, and emits attenuated 16-bit samples at the selected speed.
module playback_sequencer
  import playback_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int SHIFT      = DEF_SHIFT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    mode,
  input  logic                          play_en,
  output logic                          flash_mem_read,
  output logic [ADDR_W-1:0]             flash_mem_address,
  input  logic                          flash_mem_waitrequest,
  input  logic [31:0]                   flash_mem_readdata,
  input  logic                          flash_mem_readdatavalid,
  input  logic                          write_ready,
  output logic                          write_s,
  output logic [15:0]                   writedata_left,
  output logic [15:0]                   writedata_right,
  output logic                          wrap_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic signed [15:0] BIAS      = 16'((1 << SHIFT) - 1);

  // Divide by 2**SHIFT rounding toward zero: bias negatives before the shift.
  function automatic logic signed [15:0] scale_sample(input logic signed [15:0] x);
    logic signed [15:0] biased;
    biased = x[15] ? (x + BIAS) : x;
    return biased >>> SHIFT;
  endfunction

  fetch_state_t       fstate;
  out_state_t         ostate;
  logic [ADDR_W-1:0]  addr;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [31:0]        fifo_rdata;
  mode_t              word_mode;
  logic [1:0]         step;
  logic [31:0]        word_p1;
  logic signed [15:0] sample_p1;
  logic signed [15:0] scaled_p1;

  // Stage 0: flash fetch; at most one read outstanding, issued only with FIFO room.
  assign flash_mem_read    = (fstate == F_REQ);
  assign flash_mem_address = addr;
  assign fifo_push         = (fstate == F_DATA) && flash_mem_readdatavalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      fstate     <= F_IDLE;
      addr       <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      case (fstate)
        F_IDLE: if (play_en && !fifo_full) fstate <= F_REQ;
        F_REQ: begin
          if (!flash_mem_waitrequest) begin
            fstate <= F_DATA;
            if (addr == LAST_ADDR) begin
              addr       <= '0;
              wrap_pulse <= 1'b1;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        F_DATA: if (flash_mem_readdatavalid) fstate <= F_IDLE;
        default: fstate <= F_IDLE;
      endcase
    end
  end

  sample_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (flash_mem_readdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Stage 1: pop a word, then walk its samples in the order the latched mode dictates.
  assign fifo_pop = (ostate == O_POP);

  always_ff @(posedge clk) begin
    if (reset) begin
      ostate    <= O_IDLE;
      step      <= 2'd0;
      word_mode <= MODE_NORMAL;
    end else begin
      case (ostate)
        O_IDLE: if (!fifo_empty && play_en) ostate <= O_POP;
        O_POP: begin
          word_mode <= decode_mode(mode);
          step      <= 2'd0;
          ostate    <= O_WR;
        end
        O_WR: if (write_ready) ostate <= O_LOW;
        O_LOW: begin
          if (!write_ready) begin
            if (step == last_step(word_mode)) begin
              ostate <= O_IDLE;
            end else begin
              step   <= step + 2'd1;
              ostate <= O_WR;
            end
          end
        end
        default: ostate <= O_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ostate == O_POP) word_p1 <= fifo_rdata;
  end

  always_comb begin
    sample_p1 = step_half(word_mode, step) ? word_p1[31:16] : word_p1[15:0];
    scaled_p1 = scale_sample(sample_p1);
  end

  // Stage 2: codec handshake; data is driven only while the strobe is high.
  assign write_s         = (ostate == O_WR) && write_ready;
  assign writedata_left  = write_s ? scaled_p1 : 16'd0;
  assign writedata_right = writedata_left;

endmodule
